// File: rtl/axi_burst_mem_slv_pkg.sv
// -----------------------------------------------------------------------------
// axi_burst_mem_slv_pkg
// Shared AXI4 encodings and channel structs for the burst memory subordinate.
// The default struct widths are AddrWidth=32, DataWidth=64, IdWidth=4,
// UserWidth=5. A design built with other widths must pass matching req_t and
// resp_t types to axi_burst_mem_slv.
// -----------------------------------------------------------------------------
package axi_burst_mem_slv_pkg;

    localparam int unsigned AXI_ADDR_W = 32;
    localparam int unsigned AXI_DATA_W = 64;
    localparam int unsigned AXI_ID_W   = 4;
    localparam int unsigned AXI_USER_W = 5;
    localparam int unsigned AXI_STRB_W = AXI_DATA_W / 8;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Bit of aw.atop that requests an R response for an atomic operation
    localparam int unsigned ATOP_R_RESP = 5;

    typedef struct packed {
        logic [AXI_ID_W-1:0]   id;
        logic [AXI_ADDR_W-1:0] addr;
        logic [7:0]            len;
        logic [2:0]            size;
        logic [1:0]            burst;
        logic                  lock;
        logic [3:0]            cache;
        logic [2:0]            prot;
        logic [3:0]            qos;
        logic [3:0]            region;
        logic [5:0]            atop;
        logic [AXI_USER_W-1:0] user;
    } axi_aw_t;

    typedef struct packed {
        logic [AXI_DATA_W-1:0] data;
        logic [AXI_STRB_W-1:0] strb;
        logic                  last;
        logic [AXI_USER_W-1:0] user;
    } axi_w_t;

    typedef struct packed {
        logic [AXI_ID_W-1:0]   id;
        logic [1:0]            resp;
        logic [AXI_USER_W-1:0] user;
    } axi_b_t;

    typedef struct packed {
        logic [AXI_ID_W-1:0]   id;
        logic [AXI_ADDR_W-1:0] addr;
        logic [7:0]            len;
        logic [2:0]            size;
        logic [1:0]            burst;
        logic                  lock;
        logic [3:0]            cache;
        logic [2:0]            prot;
        logic [3:0]            qos;
        logic [3:0]            region;
        logic [AXI_USER_W-1:0] user;
    } axi_ar_t;

    typedef struct packed {
        logic [AXI_ID_W-1:0]   id;
        logic [AXI_DATA_W-1:0] data;
        logic [1:0]            resp;
        logic                  last;
        logic [AXI_USER_W-1:0] user;
    } axi_r_t;

    typedef struct packed {
        axi_aw_t aw;
        logic    aw_valid;
        axi_w_t  w;
        logic    w_valid;
        logic    b_ready;
        axi_ar_t ar;
        logic    ar_valid;
        logic    r_ready;
    } axi_req_t;

    typedef struct packed {
        logic   aw_ready;
        logic   ar_ready;
        logic   w_ready;
        logic   b_valid;
        axi_b_t b;
        logic   r_valid;
        axi_r_t r;
    } axi_resp_t;

    // WRAP is only legal for 2, 4, 8 or 16 beats; other lengths behave as INCR
    function automatic logic wrap_len_ok(input logic [7:0] len);
        logic ok;
        case (len)
            8'd1, 8'd3, 8'd7, 8'd15: ok = 1'b1;
            default:                 ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/axi_burst_mem_slv_addr_gen.sv
// -----------------------------------------------------------------------------
// axi_burst_mem_addr_gen
// Combinational next-beat address for one AXI burst.
// Ports:
//   addr_i      current beat address
//   len_i       burst length (beats - 1)
//   size_i      beat size exponent (already clamped to the bus width)
//   burst_i     FIXED / INCR / WRAP
//   next_addr_o address of the following beat (wraps modulo 2^AddrWidth)
// -----------------------------------------------------------------------------
module axi_burst_mem_addr_gen
    import axi_burst_mem_slv_pkg::*;
#(
    parameter int unsigned AddrWidth = 32
) (
    input  logic [AddrWidth-1:0] addr_i,
    input  logic [7:0]           len_i,
    input  logic [2:0]           size_i,
    input  logic [1:0]           burst_i,
    output logic [AddrWidth-1:0] next_addr_o
);

    logic [AddrWidth-1:0] step_s;
    logic [AddrWidth-1:0] aligned_s;
    logic [AddrWidth-1:0] incr_s;
    logic [AddrWidth-1:0] wrap_mask_s;

    // Step math: INCR realigns to the beat size, WRAP keeps the aligned block base
    always_comb begin
        step_s      = AddrWidth'(1) << size_i;
        aligned_s   = addr_i & ~(step_s - AddrWidth'(1));
        incr_s      = aligned_s + step_s;
        wrap_mask_s = ((AddrWidth'(len_i) + AddrWidth'(1)) << size_i) - AddrWidth'(1);
        case (burst_i)
            BURST_FIXED: next_addr_o = addr_i;
            BURST_INCR:  next_addr_o = incr_s;
            BURST_WRAP: begin
                if (wrap_len_ok(len_i)) begin
                    next_addr_o = (addr_i & ~wrap_mask_s) | (incr_s & wrap_mask_s);
                end else begin
                    next_addr_o = incr_s;
                end
            end
            default:     next_addr_o = incr_s;
        endcase
    end

endmodule

// File: rtl/axi_burst_mem_slv.sv
// -----------------------------------------------------------------------------
// axi_burst_mem_slv
// AXI4 subordinate backed by a flop-array memory. One write burst and one read
// burst are served concurrently; FIXED/INCR/WRAP bursts with byte strobes.
// Ports:
//   clk_i       clock
//   rst_ni      synchronous active-low reset (memory contents are kept)
//   slv_req_i   AW/W/AR channels plus b_ready/r_ready
//   slv_resp_o  aw/w/ar_ready plus the B and R channels (user fields 0)
// Optional feature macro: AXI_BURST_MEM_SLV_ATOP_EN
//   When defined, an AW with atop!=0 consumes its W beats without writing and
//   answers SLVERR; with atop[5] set the read side also returns len+1 error
//   beats tagged with the AW id. Without it atop is ignored.
// -----------------------------------------------------------------------------
module axi_burst_mem_slv
    import axi_burst_mem_slv_pkg::*;
#(
    parameter int unsigned AddrWidth = 32,
    parameter int unsigned DataWidth = 64,
    parameter int unsigned IdWidth   = 4,
    parameter int unsigned UserWidth = 5,
    parameter int unsigned MemWords  = 1024,
    parameter type         req_t     = axi_req_t,
    parameter type         resp_t    = axi_resp_t
) (
    input  logic  clk_i,
    input  logic  rst_ni,
    input  req_t  slv_req_i,
    output resp_t slv_resp_o
);

    localparam int unsigned StrbWidth = DataWidth / 8;
    localparam int unsigned Off       = $clog2(StrbWidth);
    localparam int unsigned IdxWidth  = $clog2(MemWords);

    localparam logic [1:0] W_IDLE = 2'd0;
    localparam logic [1:0] W_DATA = 2'd1;
    localparam logic [1:0] W_RESP = 2'd2;
    localparam logic [0:0] R_IDLE = 1'b0;
    localparam logic [0:0] R_DATA = 1'b1;

    // Beats wider than the bus are treated as full-bus beats
    function automatic logic [2:0] clamp_size(input logic [2:0] size);
        logic [2:0] res;
        if (size > 3'(Off)) begin
            res = 3'(Off);
        end else begin
            res = size;
        end
        return res;
    endfunction

    function automatic logic in_range(input logic [AddrWidth-1:0] addr);
        return (addr >> (Off + IdxWidth)) == '0;
    endfunction

    logic [DataWidth-1:0] mem_q [MemWords];

    logic                 live_q;
    logic [1:0]           w_state_q, w_state_d;
    logic [IdWidth-1:0]   w_id_q, w_id_d;
    logic [AddrWidth-1:0] w_addr_q, w_addr_d;
    logic [7:0]           w_len_q, w_len_d, w_cnt_q, w_cnt_d;
    logic [2:0]           w_size_q, w_size_d;
    logic [1:0]           w_burst_q, w_burst_d;
    logic                 w_err_q, w_err_d, w_atop_q, w_atop_d;

    logic [0:0]           r_state_q, r_state_d;
    logic [IdWidth-1:0]   r_id_q, r_id_d;
    logic [AddrWidth-1:0] r_addr_q, r_addr_d;
    logic [7:0]           r_len_q, r_len_d, r_cnt_q, r_cnt_d;
    logic [2:0]           r_size_q, r_size_d;
    logic [1:0]           r_burst_q, r_burst_d;
    logic                 r_atop_q, r_atop_d;

    logic aw_is_atop_s, aw_atop_r_s;
    logic aw_ready_s, aw_hs_s, w_ready_s, w_hs_s, b_valid_s, b_hs_s;
    logic ar_ready_s, ar_hs_s, r_valid_s, r_hs_s;
    logic w_is_last_s, r_is_last_s, w_in_range_s, r_in_range_s, mem_we_s;
    logic [AddrWidth-1:0] w_next_addr_s, r_next_addr_s;
    logic [IdxWidth-1:0]  w_idx_s, r_idx_s;
    logic [DataWidth-1:0] r_data_s;
    logic                 unused_s;

`ifdef AXI_BURST_MEM_SLV_ATOP_EN
    assign aw_is_atop_s = (slv_req_i.aw.atop != 6'd0);
    assign aw_atop_r_s  = aw_is_atop_s && slv_req_i.aw.atop[ATOP_R_RESP];
`else
    logic unused_atop_s;
    assign aw_is_atop_s  = 1'b0;
    assign aw_atop_r_s   = 1'b0;
    assign unused_atop_s = ^slv_req_i.aw.atop;
`endif

    assign unused_s = ^{slv_req_i.aw.lock, slv_req_i.aw.cache, slv_req_i.aw.prot,
                        slv_req_i.aw.qos, slv_req_i.aw.region, slv_req_i.aw.user,
                        slv_req_i.w.user, slv_req_i.ar.lock, slv_req_i.ar.cache,
                        slv_req_i.ar.prot, slv_req_i.ar.qos, slv_req_i.ar.region,
                        slv_req_i.ar.user};

    // An R-responding atomic AW needs the read side, so it waits for it and
    // blocks AR in the cycle it is offered to avoid a double claim.
    assign aw_ready_s = live_q && (w_state_q == W_IDLE) && !(aw_atop_r_s && (r_state_q != R_IDLE));
    assign ar_ready_s = live_q && (r_state_q == R_IDLE)
                        && !(slv_req_i.aw_valid && aw_atop_r_s && (w_state_q == W_IDLE));
    assign aw_hs_s    = slv_req_i.aw_valid && aw_ready_s;
    assign w_ready_s  = (w_state_q == W_DATA);
    assign w_hs_s     = slv_req_i.w_valid && w_ready_s;
    assign b_valid_s  = (w_state_q == W_RESP);
    assign b_hs_s     = b_valid_s && slv_req_i.b_ready;
    assign ar_hs_s    = slv_req_i.ar_valid && ar_ready_s;
    assign r_valid_s  = (r_state_q == R_DATA);
    assign r_hs_s     = r_valid_s && slv_req_i.r_ready;

    assign w_is_last_s  = (w_cnt_q == w_len_q);
    assign r_is_last_s  = (r_cnt_q == r_len_q);
    assign w_in_range_s = in_range(w_addr_q);
    assign r_in_range_s = in_range(r_addr_q);
    assign w_idx_s      = w_addr_q[Off +: IdxWidth];
    assign r_idx_s      = r_addr_q[Off +: IdxWidth];

    axi_burst_mem_addr_gen #(.AddrWidth(AddrWidth)) u_w_addr_gen (
        .addr_i      (w_addr_q),
        .len_i       (w_len_q),
        .size_i      (w_size_q),
        .burst_i     (w_burst_q),
        .next_addr_o (w_next_addr_s)
    );

    axi_burst_mem_addr_gen #(.AddrWidth(AddrWidth)) u_r_addr_gen (
        .addr_i      (r_addr_q),
        .len_i       (r_len_q),
        .size_i      (r_size_q),
        .burst_i     (r_burst_q),
        .next_addr_o (r_next_addr_s)
    );

    // Write FSM next state: latch AW, absorb W beats, hold B until accepted
    always_comb begin
        w_state_d = w_state_q;
        w_id_d    = w_id_q;
        w_addr_d  = w_addr_q;
        w_len_d   = w_len_q;
        w_size_d  = w_size_q;
        w_burst_d = w_burst_q;
        w_cnt_d   = w_cnt_q;
        w_err_d   = w_err_q;
        w_atop_d  = w_atop_q;
        mem_we_s  = 1'b0;
        case (w_state_q)
            W_IDLE: begin
                if (aw_hs_s) begin
                    w_id_d    = slv_req_i.aw.id;
                    w_addr_d  = slv_req_i.aw.addr;
                    w_len_d   = slv_req_i.aw.len;
                    w_size_d  = clamp_size(slv_req_i.aw.size);
                    w_burst_d = slv_req_i.aw.burst;
                    w_cnt_d   = 8'd0;
                    w_err_d   = aw_is_atop_s;
                    w_atop_d  = aw_is_atop_s;
                    w_state_d = W_DATA;
                end else begin
                    w_state_d = W_IDLE;
                end
            end
            W_DATA: begin
                if (w_hs_s) begin
                    if (!w_in_range_s || (slv_req_i.w.last != w_is_last_s)) begin
                        w_err_d = 1'b1;
                    end else begin
                        w_err_d = w_err_q;
                    end
                    mem_we_s = w_in_range_s && !w_atop_q;
                    w_addr_d = w_next_addr_s;
                    w_cnt_d  = w_cnt_q + 8'd1;
                    if (w_is_last_s) begin
                        w_state_d = W_RESP;
                    end else begin
                        w_state_d = W_DATA;
                    end
                end else begin
                    w_state_d = W_DATA;
                end
            end
            W_RESP: begin
                if (b_hs_s) begin
                    w_state_d = W_IDLE;
                end else begin
                    w_state_d = W_RESP;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    // Read FSM next state: latch AR (or an R-responding atomic AW), step on R handshakes
    always_comb begin
        r_state_d = r_state_q;
        r_id_d    = r_id_q;
        r_addr_d  = r_addr_q;
        r_len_d   = r_len_q;
        r_size_d  = r_size_q;
        r_burst_d = r_burst_q;
        r_cnt_d   = r_cnt_q;
        r_atop_d  = r_atop_q;
        case (r_state_q)
            R_IDLE: begin
                if (ar_hs_s) begin
                    r_id_d    = slv_req_i.ar.id;
                    r_addr_d  = slv_req_i.ar.addr;
                    r_len_d   = slv_req_i.ar.len;
                    r_size_d  = clamp_size(slv_req_i.ar.size);
                    r_burst_d = slv_req_i.ar.burst;
                    r_cnt_d   = 8'd0;
                    r_atop_d  = 1'b0;
                    r_state_d = R_DATA;
                end else if (aw_hs_s && aw_atop_r_s) begin
                    r_id_d    = slv_req_i.aw.id;
                    r_addr_d  = slv_req_i.aw.addr;
                    r_len_d   = slv_req_i.aw.len;
                    r_size_d  = clamp_size(slv_req_i.aw.size);
                    r_burst_d = BURST_FIXED;
                    r_cnt_d   = 8'd0;
                    r_atop_d  = 1'b1;
                    r_state_d = R_DATA;
                end else begin
                    r_state_d = R_IDLE;
                end
            end
            R_DATA: begin
                if (r_hs_s) begin
                    r_addr_d = r_next_addr_s;
                    r_cnt_d  = r_cnt_q + 8'd1;
                    if (r_is_last_s) begin
                        r_state_d = R_IDLE;
                    end else begin
                        r_state_d = R_DATA;
                    end
                end else begin
                    r_state_d = R_DATA;
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    // Control and burst registers; ready outputs open one cycle after reset release
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            live_q    <= 1'b0;
            w_state_q <= W_IDLE;
            w_id_q    <= '0;
            w_addr_q  <= '0;
            w_len_q   <= 8'd0;
            w_size_q  <= 3'd0;
            w_burst_q <= 2'd0;
            w_cnt_q   <= 8'd0;
            w_err_q   <= 1'b0;
            w_atop_q  <= 1'b0;
            r_state_q <= R_IDLE;
            r_id_q    <= '0;
            r_addr_q  <= '0;
            r_len_q   <= 8'd0;
            r_size_q  <= 3'd0;
            r_burst_q <= 2'd0;
            r_cnt_q   <= 8'd0;
            r_atop_q  <= 1'b0;
        end else begin
            live_q    <= 1'b1;
            w_state_q <= w_state_d;
            w_id_q    <= w_id_d;
            w_addr_q  <= w_addr_d;
            w_len_q   <= w_len_d;
            w_size_q  <= w_size_d;
            w_burst_q <= w_burst_d;
            w_cnt_q   <= w_cnt_d;
            w_err_q   <= w_err_d;
            w_atop_q  <= w_atop_d;
            r_state_q <= r_state_d;
            r_id_q    <= r_id_d;
            r_addr_q  <= r_addr_d;
            r_len_q   <= r_len_d;
            r_size_q  <= r_size_d;
            r_burst_q <= r_burst_d;
            r_cnt_q   <= r_cnt_d;
            r_atop_q  <= r_atop_d;
        end
    end

    // Byte-strobed memory write; contents are deliberately not reset
    always_ff @(posedge clk_i) begin
        if (mem_we_s) begin
            for (int i = 0; i < StrbWidth; i++) begin
                if (slv_req_i.w.strb[i]) begin
                    mem_q[w_idx_s][i*8 +: 8] <= slv_req_i.w.data[i*8 +: 8];
                end
            end
        end
    end

    // Combinational read: a same-cycle write to this word is seen only next cycle
    always_comb begin
        if (r_valid_s && !r_atop_q && r_in_range_s) begin
            r_data_s = mem_q[r_idx_s];
        end else begin
            r_data_s = '0;
        end
    end

    // Response port assembly; id/resp/last are zero whenever their valid is low
    always_comb begin
        slv_resp_o          = '0;
        slv_resp_o.aw_ready = aw_ready_s;
        slv_resp_o.w_ready  = w_ready_s;
        slv_resp_o.ar_ready = ar_ready_s;
        slv_resp_o.b_valid  = b_valid_s;
        slv_resp_o.b.user   = {UserWidth{1'b0}};
        slv_resp_o.r_valid  = r_valid_s;
        slv_resp_o.r.user   = {UserWidth{1'b0}};
        slv_resp_o.r.data   = r_data_s;
        if (b_valid_s) begin
            slv_resp_o.b.id   = w_id_q;
            slv_resp_o.b.resp = w_err_q ? RESP_SLVERR : RESP_OKAY;
        end else begin
            slv_resp_o.b.id   = '0;
            slv_resp_o.b.resp = RESP_OKAY;
        end
        if (r_valid_s) begin
            slv_resp_o.r.id   = r_id_q;
            slv_resp_o.r.resp = (r_atop_q || !r_in_range_s) ? RESP_SLVERR : RESP_OKAY;
            slv_resp_o.r.last = r_is_last_s;
        end else begin
            slv_resp_o.r.id   = '0;
            slv_resp_o.r.resp = RESP_OKAY;
            slv_resp_o.r.last = 1'b0;
        end
    end

endmodule

// File: tb/tb_axi_burst_mem_slv.sv
// -----------------------------------------------------------------------------
// tb_axi_burst_mem_slv
// Directed table of write/read bursts with hand-computed expectations, plus
// hand-written sequences for reset, concurrent AW/AR and mid-burst reset.
// -----------------------------------------------------------------------------
module tb_axi_burst_mem_slv;
    import axi_burst_mem_slv_pkg::*;

    typedef struct {
        bit          is_wr;
        bit          bad_last;
        logic [3:0]  id;
        logic [31:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
        logic [7:0]  strb;
        logic [63:0] d0;
        logic [1:0]  exp_resp;
        logic [63:0] exp_d [4];
    } vec_t;

    localparam int NV = 16;

    logic      clk = 1'b0;
    logic      rst_n;
    axi_req_t  req;
    axi_resp_t rsp;
    int        n_cmp = 0;
    int        n_err = 0;
    vec_t      vecs [NV];
    logic [1:0] bresp;
    logic [3:0] bid;

    always #5 clk = ~clk;

    axi_burst_mem_slv #(
        .AddrWidth(32), .DataWidth(64), .IdWidth(4), .UserWidth(5), .MemWords(1024),
        .req_t(axi_req_t), .resp_t(axi_resp_t)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .slv_req_i  (req),
        .slv_resp_o (rsp)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic sel(input int which);
        logic v;
        case (which)
            0:       v = rsp.aw_ready;
            1:       v = rsp.w_ready;
            2:       v = rsp.b_valid;
            3:       v = rsp.ar_ready;
            default: v = rsp.r_valid;
        endcase
        return v;
    endfunction

    // Returns at a negedge where the selected ready/valid is high (bounded wait)
    task automatic wait_hs(input int which, input string name);
        int t = 0;
        @(negedge clk);
        while (!sel(which) && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!sel(which)) begin
            n_cmp++;
            n_err++;
            $display("FAIL timeout %s: got 0, want 1 within 200 cycles", name);
        end
    endtask

    function automatic vec_t mk(input bit wr, input bit bad, input logic [3:0] id,
                                input logic [31:0] addr, input logic [7:0] len,
                                input logic [2:0] size, input logic [1:0] burst,
                                input logic [7:0] strb, input logic [63:0] d0,
                                input logic [1:0] resp, input logic [63:0] e0,
                                input logic [63:0] e1, input logic [63:0] e2,
                                input logic [63:0] e3);
        vec_t v;
        v.is_wr = wr; v.bad_last = bad; v.id = id; v.addr = addr; v.len = len;
        v.size = size; v.burst = burst; v.strb = strb; v.d0 = d0; v.exp_resp = resp;
        v.exp_d[0] = e0; v.exp_d[1] = e1; v.exp_d[2] = e2; v.exp_d[3] = e3;
        return v;
    endfunction

    task automatic do_write(input vec_t v, input logic [5:0] atop,
                            output logic [1:0] resp_o, output logic [3:0] id_o);
        req.aw       = '0;
        req.aw.id    = v.id;
        req.aw.addr  = v.addr;
        req.aw.len   = v.len;
        req.aw.size  = v.size;
        req.aw.burst = v.burst;
        req.aw.atop  = atop;
        req.aw_valid = 1'b1;
        wait_hs(0, "aw_ready");
        @(posedge clk); #1;
        req.aw_valid = 1'b0;
        for (int k = 0; k <= int'(v.len); k++) begin
            req.w.data  = v.d0 + 64'(k);
            req.w.strb  = v.strb;
            req.w.last  = (k == int'(v.len)) || v.bad_last;
            req.w_valid = 1'b1;
            wait_hs(1, "w_ready");
            @(posedge clk); #1;
        end
        req.w_valid = 1'b0;
        req.b_ready = 1'b1;
        wait_hs(2, "b_valid");
        resp_o = rsp.b.resp;
        id_o   = rsp.b.id;
        @(posedge clk); #1;
        req.b_ready = 1'b0;
    endtask

    task automatic do_read(input int idx, input vec_t v);
        req.ar       = '0;
        req.ar.id    = v.id;
        req.ar.addr  = v.addr;
        req.ar.len   = v.len;
        req.ar.size  = v.size;
        req.ar.burst = v.burst;
        req.ar_valid = 1'b1;
        wait_hs(3, "ar_ready");
        @(posedge clk); #1;
        req.ar_valid = 1'b0;
        req.r_ready  = 1'b1;
        for (int k = 0; k <= int'(v.len); k++) begin
            wait_hs(4, "r_valid");
            chk($sformatf("v%0d beat%0d r_data", idx, k), rsp.r.data, v.exp_d[k]);
            chk($sformatf("v%0d beat%0d r_resp", idx, k), 64'(rsp.r.resp), 64'(v.exp_resp));
            chk($sformatf("v%0d beat%0d r_last", idx, k), 64'(rsp.r.last), 64'(k == int'(v.len)));
            chk($sformatf("v%0d beat%0d r_id", idx, k), 64'(rsp.r.id), 64'(v.id));
            @(posedge clk); #1;
        end
        req.r_ready = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        req   = '0;
        rst_n = 1'b0;

        //           wr    bad   id     addr          len   sz    burst        strb   d0                      resp         exp0..exp3
        vecs[0]  = mk(1'b1, 1'b0, 4'h1, 32'h0000_0040, 8'd3, 3'd3, BURST_INCR,  8'hFF, 64'h1,                  RESP_OKAY,   64'h0, 64'h0, 64'h0, 64'h0);
        vecs[1]  = mk(1'b0, 1'b0, 4'h2, 32'h0000_0040, 8'd3, 3'd3, BURST_INCR,  8'h00, 64'h0,                  RESP_OKAY,   64'h1, 64'h2, 64'h3, 64'h4);
        vecs[2]  = mk(1'b1, 1'b0, 4'h3, 32'h0000_0018, 8'd3, 3'd3, BURST_WRAP,  8'hFF, 64'h100,                RESP_OKAY,   64'h0, 64'h0, 64'h0, 64'h0);
        vecs[3]  = mk(1'b0, 1'b0, 4'h4, 32'h0000_0000, 8'd3, 3'd3, BURST_INCR,  8'h00, 64'h0,                  RESP_OKAY,   64'h101, 64'h102, 64'h103, 64'h100);
        vecs[4]  = mk(1'b0, 1'b0, 4'h5, 32'h0000_0018, 8'd3, 3'd3, BURST_WRAP,  8'h00, 64'h0,                  RESP_OKAY,   64'h100, 64'h101, 64'h102, 64'h103);
        vecs[5]  = mk(1'b1, 1'b0, 4'h6, 32'h0000_0080, 8'd3, 3'd3, BURST_FIXED, 8'hFF, 64'h200,                RESP_OKAY,   64'h0, 64'h0, 64'h0, 64'h0);
        vecs[6]  = mk(1'b0, 1'b0, 4'h7, 32'h0000_0080, 8'd1, 3'd3, BURST_FIXED, 8'h00, 64'h0,                  RESP_OKAY,   64'h203, 64'h203, 64'h0, 64'h0);
        vecs[7]  = mk(1'b1, 1'b0, 4'h8, 32'h0000_0100, 8'd0, 3'd3, BURST_INCR,  8'hFF, 64'h0,                  RESP_OKAY,   64'h0, 64'h0, 64'h0, 64'h0);
        vecs[8]  = mk(1'b1, 1'b0, 4'h9, 32'h0000_0100, 8'd0, 3'd3, BURST_INCR,  8'h0F, 64'hAAAA_AAAA_AAAA_AAAA, RESP_OKAY,   64'h0, 64'h0, 64'h0, 64'h0);
        vecs[9]  = mk(1'b0, 1'b0, 4'hA, 32'h0000_0100, 8'd0, 3'd3, BURST_INCR,  8'h00, 64'h0,                  RESP_OKAY,   64'h0000_0000_AAAA_AAAA, 64'h0, 64'h0, 64'h0);
        vecs[10] = mk(1'b1, 1'b0, 4'hB, 32'h0000_2000, 8'd1, 3'd3, BURST_INCR,  8'hFF, 64'hDEAD,               RESP_SLVERR, 64'h0, 64'h0, 64'h0, 64'h0);
        vecs[11] = mk(1'b0, 1'b0, 4'hC, 32'h0000_2000, 8'd1, 3'd3, BURST_INCR,  8'h00, 64'h0,                  RESP_SLVERR, 64'h0, 64'h0, 64'h0, 64'h0);
        vecs[12] = mk(1'b0, 1'b0, 4'hD, 32'h0000_0000, 8'd1, 3'd3, BURST_INCR,  8'h00, 64'h0,                  RESP_OKAY,   64'h101, 64'h102, 64'h0, 64'h0);
        vecs[13] = mk(1'b0, 1'b0, 4'hE, 32'h0000_0043, 8'd1, 3'd3, BURST_INCR,  8'h00, 64'h0,                  RESP_OKAY,   64'h1, 64'h2, 64'h0, 64'h0);
        vecs[14] = mk(1'b0, 1'b0, 4'h1, 32'h0000_0044, 8'd2, 3'd2, BURST_INCR,  8'h00, 64'h0,                  RESP_OKAY,   64'h1, 64'h2, 64'h2, 64'h0);
        vecs[15] = mk(1'b1, 1'b1, 4'hF, 32'h0000_0040, 8'd1, 3'd3, BURST_INCR,  8'hFF, 64'h900,                RESP_SLVERR, 64'h0, 64'h0, 64'h0, 64'h0);

        // Reset state while rst_n is held low
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst aw_ready", 64'(rsp.aw_ready), 64'h0);
        chk("rst ar_ready", 64'(rsp.ar_ready), 64'h0);
        chk("rst w_ready",  64'(rsp.w_ready),  64'h0);
        chk("rst b_valid",  64'(rsp.b_valid),  64'h0);
        chk("rst r_valid",  64'(rsp.r_valid),  64'h0);
        chk("rst r_data",   rsp.r.data,        64'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("post-rst aw_ready", 64'(rsp.aw_ready), 64'h1);
        chk("post-rst ar_ready", 64'(rsp.ar_ready), 64'h1);
        @(posedge clk); #1;

        // Table-driven bursts
        for (int i = 0; i < NV; i++) begin
            if (vecs[i].is_wr) begin
                do_write(vecs[i], 6'd0, bresp, bid);
                chk($sformatf("v%0d b_resp", i), 64'(bresp), 64'(vecs[i].exp_resp));
                chk($sformatf("v%0d b_id", i),   64'(bid),   64'(vecs[i].id));
            end else begin
                do_read(i, vecs[i]);
            end
        end

        // Word 5 preset, then AW and AR accepted together: R sees the old word
        do_write(mk(1'b1, 1'b0, 4'h2, 32'h28, 8'd0, 3'd3, BURST_INCR, 8'hFF, 64'h55,
                    RESP_OKAY, 64'h0, 64'h0, 64'h0, 64'h0), 6'd0, bresp, bid);
        chk("w5 preset b_resp", 64'(bresp), 64'(RESP_OKAY));
        req.aw = '0; req.aw.id = 4'h2; req.aw.addr = 32'h28; req.aw.size = 3'd3; req.aw.burst = BURST_INCR;
        req.ar = '0; req.ar.id = 4'h3; req.ar.addr = 32'h28; req.ar.size = 3'd3; req.ar.burst = BURST_INCR;
        req.aw_valid = 1'b1; req.ar_valid = 1'b1;
        req.w.data = 64'h77; req.w.strb = 8'hFF; req.w.last = 1'b1; req.w_valid = 1'b1;
        req.r_ready = 1'b1;
        @(negedge clk);
        chk("same-cycle aw_ready", 64'(rsp.aw_ready), 64'h1);
        chk("same-cycle ar_ready", 64'(rsp.ar_ready), 64'h1);
        @(posedge clk); #1;
        req.aw_valid = 1'b0; req.ar_valid = 1'b0;
        @(negedge clk);
        chk("same-cycle w_ready", 64'(rsp.w_ready), 64'h1);
        chk("same-cycle r_valid", 64'(rsp.r_valid), 64'h1);
        chk("same-cycle r_data old", rsp.r.data, 64'h55);
        chk("same-cycle r_last", 64'(rsp.r.last), 64'h1);
        @(posedge clk); #1;
        req.w_valid = 1'b0; req.r_ready = 1'b0; req.b_ready = 1'b1;
        @(negedge clk);
        chk("same-cycle b_valid", 64'(rsp.b_valid), 64'h1);
        chk("same-cycle b_resp", 64'(rsp.b.resp), 64'(RESP_OKAY));
        @(posedge clk); #1;
        req.b_ready = 1'b0;
        do_read(100, mk(1'b0, 1'b0, 4'h4, 32'h28, 8'd0, 3'd3, BURST_INCR, 8'h00, 64'h0,
                        RESP_OKAY, 64'h77, 64'h0, 64'h0, 64'h0));

`ifdef AXI_BURST_MEM_SLV_ATOP_EN
        // Atomic with R response: no write, SLVERR on B and len+1 error R beats
        do_write(mk(1'b1, 1'b0, 4'h6, 32'h28, 8'd1, 3'd3, BURST_INCR, 8'hFF, 64'h99,
                    RESP_SLVERR, 64'h0, 64'h0, 64'h0, 64'h0), 6'h31, bresp, bid);
        chk("atop b_resp", 64'(bresp), 64'(RESP_SLVERR));
        req.r_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            wait_hs(4, "atop r_valid");
            chk($sformatf("atop beat%0d r_data", k), rsp.r.data, 64'h0);
            chk($sformatf("atop beat%0d r_resp", k), 64'(rsp.r.resp), 64'(RESP_SLVERR));
            chk($sformatf("atop beat%0d r_id", k), 64'(rsp.r.id), 64'h6);
            chk($sformatf("atop beat%0d r_last", k), 64'(rsp.r.last), 64'(k == 1));
            @(posedge clk); #1;
        end
        req.r_ready = 1'b0;
        do_read(101, mk(1'b0, 1'b0, 4'h4, 32'h28, 8'd0, 3'd3, BURST_INCR, 8'h00, 64'h0,
                        RESP_OKAY, 64'h77, 64'h0, 64'h0, 64'h0));
`endif

        // Reset during beat 3 of an 8-beat write
        req.aw = '0; req.aw.id = 4'h9; req.aw.addr = 32'h300; req.aw.len = 8'd7;
        req.aw.size = 3'd3; req.aw.burst = BURST_INCR; req.aw_valid = 1'b1;
        wait_hs(0, "mid aw_ready");
        @(posedge clk); #1;
        req.aw_valid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            req.w.data = 64'h300 + 64'(k); req.w.strb = 8'hFF; req.w.last = 1'b0; req.w_valid = 1'b1;
            wait_hs(1, "mid w_ready");
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("mid-rst w_ready",  64'(rsp.w_ready),  64'h0);
        chk("mid-rst aw_ready", 64'(rsp.aw_ready), 64'h0);
        chk("mid-rst b_valid",  64'(rsp.b_valid),  64'h0);
        chk("mid-rst r_valid",  64'(rsp.r_valid),  64'h0);
        @(posedge clk); #1;
        rst_n = 1'b1; req.w_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("mid-rst release aw_ready", 64'(rsp.aw_ready), 64'h1);
        chk("mid-rst release ar_ready", 64'(rsp.ar_ready), 64'h1);
        chk("mid-rst release w_ready",  64'(rsp.w_ready),  64'h0);
        @(posedge clk); #1;
        do_read(102, mk(1'b0, 1'b0, 4'h3, 32'h0, 8'd0, 3'd3, BURST_INCR, 8'h00, 64'h0,
                        RESP_OKAY, 64'h101, 64'h0, 64'h0, 64'h0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
